// File: rtl/multicycle_adder_pkg.sv
// Shared types and default sizing for the chunked multicycle adder.
// The FSM state enum lives here so sub-blocks and benches agree on it.
package multicycle_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/ripple_adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into
// the MSB so the caller can form two's-complement overflow.
module ripple_adder_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] X,
   input  logic [CHUNK-1:0] Y,
   input  logic             Cin,
   output logic [CHUNK-1:0] S,
   output logic             Cout,
   output logic             Cmsb
);

   logic [CHUNK:0] c;

   // bit-serial carry chain across the chunk
   always_comb begin
      c    = '0;
      S    = '0;
      c[0] = Cin;
      for (int i = 0; i < CHUNK; i++) begin
         S[i]   = X[i] ^ Y[i] ^ c[i];
         c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
      end
      Cout = c[CHUNK];
      Cmsb = c[CHUNK-1];
   end

endmodule

// File: rtl/multicycle_adder.sv
// Adds/subtracts WIDTH-bit operands CHUNK bits per clock, LSB chunk
// first, through one shared ripple chunk; results post with done.
module multicycle_adder
   import multicycle_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V,
   output logic             Z
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_size
      $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
   end

   state_t           state_q, state_d;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_q, b_q, acc, full;
   logic             c_q;
   logic             load, step, fin, last;
   logic [CHUNK-1:0] ch_s;
   logic             ch_cout, ch_cmsb;

   assign busy = (state_q == RUN);
   assign last = (idx == IW'(NCHUNK - 1));

   ripple_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .X    (a_q[idx*CHUNK +: CHUNK]),
      .Y    (b_q[idx*CHUNK +: CHUNK]),
      .Cin  (c_q),
      .S    (ch_s),
      .Cout (ch_cout),
      .Cmsb (ch_cmsb)
   );

   // merge the current chunk into the accumulated partial sum
   always_comb begin
      full = acc;
      full[idx*CHUNK +: CHUNK] = ch_s;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state and datapath strobes
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_d = IDLE;
               fin     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // operand latch, chunk stepping and result publication
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         c_q  <= 1'b0;
         acc  <= '0;
         idx  <= '0;
         done <= 1'b0;
         S    <= '0;
         Cout <= 1'b0;
         V    <= 1'b0;
         Z    <= 1'b0;
      end else begin
         done <= fin;
         if (load) begin
            a_q <= X;
            b_q <= sub ? ~Y : Y;
            c_q <= sub | Cin;
            acc <= '0;
            idx <= '0;
         end else if (step) begin
            acc <= full;
            c_q <= ch_cout;
            idx <= fin ? '0 : idx + IW'(1);
            if (fin) begin
               S    <= full;
               Cout <= ch_cout;
               V    <= ch_cout ^ ch_cmsb;
               Z    <= ~|full;
            end
         end
      end
   end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, the bits added per clock cycle.
REQ-003 WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK; other values are illegal and SHALL fail elaboration.
REQ-004 clk  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 X  input  WIDTH  operand A; sampled with start.
REQ-008 Y  input  WIDTH  operand B; sampled with start.
REQ-009 Cin  input  1  carry-in; sampled with start.
REQ-010 sub  input  1  mode (0 = add, 1 = subtract); sampled with start.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse; result valid.
REQ-013 S  output  WIDTH  sum or difference.
REQ-014 Cout  output  1  carry out of bit WIDTH-1.
REQ-015 V  output  1  two's-complement overflow.
REQ-016 Z  output  1  high when S is all zeros.

Function
REQ-017 The FSM SHALL have two states, IDLE and RUN, plus a chunk index counter of width $clog2(NCHUNK) bits, minimum 1.
REQ-018 IDLE -> RUN: when start = 1 at edge k, the block SHALL latch X, Y, Cin and sub, clear the chunk index, and set busy = 1 from edge k.
REQ-019 In RUN, edge k+1+i SHALL add chunk i (bits i*CHUNK .. i*CHUNK+CHUNK-1) and register the carry for chunk i+1; chunk 0 is the LSB chunk and uses the latched carry-in.
REQ-020 Add mode SHALL compute X + Y + Cin.
REQ-021 Subtract mode SHALL compute X + ~Y + 1; Cin SHALL be ignored.
REQ-022 RUN -> IDLE: at edge k+NCHUNK the last chunk SHALL complete, busy SHALL drop, and done SHALL be 1 for exactly one cycle.
REQ-023 Latency from the start edge to the done edge SHALL be NCHUNK cycles; back-to-back throughput SHALL be one operation per NCHUNK+1 cycles.
REQ-024 S, Cout, V and Z SHALL update only at the edge that asserts done, and SHALL hold until the next done; partial sums SHALL stay internal.
REQ-025 V SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-026 Z SHALL be derived from the final S.
REQ-027 start while busy = 1 SHALL be ignored, and input changes during RUN SHALL have no effect.
REQ-028 start = 1 in the cycle where done = 1 (state IDLE) SHALL be accepted as a new operation.
REQ-029 When CHUNK = WIDTH, the latency SHALL be 1 cycle.
REQ-030 Carry SHALL wrap out as Cout only; no carry SHALL be retained between operations.

Reset
REQ-031 rst_n = 0 SHALL asynchronously force state IDLE, chunk index 0, busy = 0, done = 0, S = 0, Cout = 0, V = 0 and Z = 0, including mid-operation, which aborts the operation with no done.
REQ-032 After rst_n rises, the first start SHALL be accepted on the first rising edge.

Structure
REQ-033 Package multicycle_adder_pkg SHALL hold the FSM state enum (IDLE, RUN) and the default WIDTH/CHUNK constants.
REQ-034 Sub-module ripple_adder_chunk SHALL be a combinational CHUNK-bit ripple adder (X, Y, Cin -> S, Cout, plus carry into the MSB), instantiated once and reused every cycle.

Verification
REQ-035 WIDTH=32, CHUNK=8: X=0x00000001, Y=0, Cin=0, sub=0 -> done 4 cycles after start; S=0x00000001, Cout=0, V=0, Z=0.
REQ-036 X=0xFFFFFFFF, Y=0x00000001, Cin=0, add -> S=0, Cout=1, V=0, Z=1; busy high for exactly 4 cycles.
REQ-037 X=0x7FFFFFFF, Y=1, add -> S=0x80000000, V=1, Cout=0; then sub with X=5, Y=7 -> S=0xFFFFFFFE, Cout=0, V=0.
REQ-038 Second start pulsed during RUN -> ignored, one done only; start in the done cycle -> accepted, next done 4 cycles later.
REQ-039 rst_n asserted two cycles into RUN -> busy=0 immediately, no done, outputs 0; a new operation after release completes correctly.
REQ-040 WIDTH=16, CHUNK=16: X=0x8000, Y=0x8000 -> done 1 cycle after start; S=0, Cout=1, V=1, Z=1.
